uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1/9600 receiver.
- Configurable data width, parity and stop bits; 16x-style oversampling with 3-sample majority vote at bit centre.
- Delivers each frame over a valid/ready handshake, with per-frame parity and framing error flags and an overrun pulse.
- Sits between the board RX pin and the byte-consumer logic (command parser / FIFO).

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115_200, line bit rate in bit/s
OVERSAMPLE, 16, samples per bit; even, minimum 8
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
rx  in  1  serial line, idle high, asynchronous to clk
rx_data  out  DATA_BITS  received word, LSB = first bit on the line
rx_valid  out  1  rx_data/err flags valid; held until accepted
rx_ready  in  1  consumer accepts word when rx_valid & rx_ready
parity_err  out  1  parity mismatch for the presented word (0 when PARITY=0)
frame_err  out  1  a stop bit sampled low for the presented word
overrun  out  1  one-cycle pulse: completed frame dropped because rx_valid was still pending

Behaviour:
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, FSM=IDLE, synchroniser flops=1. Reset mid-frame aborts the frame silently.
- rx passes through a 2-flop synchroniser (reset to 1). All sampling uses the synchronised signal.
- Tick generator: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation.
  - Produces a 1-cycle sample tick every DIV clocks.
  - Counter is cleared on start detection, so the first tick comes DIV clocks after the edge.
- Tick counter within a bit runs 0..OVERSAMPLE-1.
- Bit value = majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- FSM states and transitions:
  - IDLE: wait for synchronised rx 1->0. Then go to START and clear the counters.
  - START: at the majority point, a vote of 1 is a false start: return to IDLE, produce no output. A vote of 0 continues to the start bit's end, then DATA.
  - DATA: shift in DATA_BITS bits, LSB first, one per bit period. Then go to PARITY if PARITY!=0, else STOP.
  - PARITY: sample one bit. Odd: data XOR parity must be 1. Even: it must be 0. Record the mismatch.
  - STOP: sample STOP_BITS bits. Any stop vote of 0 sets the frame error.
    - Leave STOP at the majority point of the last stop bit, not at its end, so the receiver resynchronises on an early next start edge.
    - On leaving, perform the delivery step below, then go to IDLE.
- Delivery step:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load rx_data, parity_err and frame_err, and set rx_valid=1.
  - Else keep the old word and flags, and pulse overrun for 1 cycle.
- Handshake:
  - rx_valid falls the cycle after rx_valid & rx_ready, unless a new word loads in that same cycle.
  - rx_data and the flags are stable while rx_valid=1.
- Frames with parity_err or frame_err are still delivered; the consumer decides.
- Latency: rx_valid rises 3 clk after the majority point of the last stop bit (2 synchroniser stages + 1 register).
- Line held low after a frame error: no new start until rx returns high. IDLE requires a seen-high level before accepting a falling edge.

Optional Feature:
UART_RX_BREAK_DET_EN
- Defined: adds output break_det (1 bit, reset 0).
  - If the frame error occurs with all data bits 0 and rx still low, the frame is not delivered and no overrun is raised.
  - break_det pulses 1 cycle when rx has been continuously low for (DATA_BITS+STOP_BITS+2) bit periods.
  - The FSM then waits in IDLE for rx high.
- Undefined: no break_det port; such frames are delivered as 0 with frame_err=1.

Test Plan:
All cases use defaults (DIV=27, bit period 432 clk) unless stated.
1. Frame 0xA5, rx_ready=1 -> rx_data=0xA5, parity_err=0, frame_err=0; rx_valid high 1 cycle, rising ≈ 9.5 bit periods + 3 clk after the start edge.
2. rx low glitch of 100 clk -> no rx_valid, FSM back in IDLE; a following frame 0x3C is received correctly.
3. PARITY=2, frame 0x3C sent with parity bit 1 (correct is 0) -> rx_data=0x3C, parity_err=1; same frame with parity 0 -> parity_err=0.
4. Frame 0x55 with stop bit 0, then line high -> rx_data=0x55, frame_err=1; next frame 0x12 gives frame_err=0.
5. rx_ready=0, frames 0x11 then 0x22 back-to-back -> rx_data stays 0x11, one overrun pulse at the end of the 2nd frame; rx_ready=1 then gives rx_valid low the next cycle, and 0x22 is never presented.
6. DATA_BITS=7, STOP_BITS=2, frame 0x7F; then assert rst mid-frame -> first gives rx_data=0x7F; after reset all outputs are 0 and the following frame 0x01 is received cleanly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised oversampling UART receiver with valid/ready word output.
// Define UART_RX_BREAK_DET_EN to add the break_det output and break-frame suppression.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_BREAK_DET_EN
    output logic                 break_det,
`endif
    output logic [2:0]           dbg_state
);

    // Handshake: a word transfers on any rising clk edge where rx_valid & rx_ready;
    // rx_data/parity_err/frame_err stay stable from rx_valid rising until that transfer.

    localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] S0        = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] S1        = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] S2        = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_rx_s1;
    logic                 r_rx_s2;
    logic                 r_seen_high;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [3:0]           r_bit_cnt;
    logic                 r_samp0;
    logic                 r_samp1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr_o;
    logic                 r_ferr_o;
    logic                 r_overrun;

    logic w_rx;
    logic w_tick;
    logic w_mid;
    logic w_end;
    logic w_vote;
    logic w_ferr_now;
    logic w_par_bad;
    logic w_can_load;
    logic w_break_frame;

    assign w_rx       = r_rx_s2;
    assign w_tick     = (r_div_cnt == DIV_LAST);
    assign w_mid      = w_tick && (r_tick_cnt == S2);
    assign w_end      = w_tick && (r_tick_cnt == TICK_LAST);
    // Third sample is taken live at the vote tick, so the vote resolves at S2.
    assign w_vote     = (r_samp0 & r_samp1) | (r_samp0 & w_rx) | (r_samp1 & w_rx);
    assign w_ferr_now = r_ferr | ~w_vote;
    assign w_can_load = ~r_valid | rx_ready;

    always_comb begin
        w_par_bad = 1'b0;
        if (PARITY == 1) begin
            w_par_bad = ~(^r_shift ^ w_vote);
        end else if (PARITY == 2) begin
            w_par_bad = ^r_shift ^ w_vote;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    localparam int BRK_CLKS = (DATA_BITS + STOP_BITS + 2) * OVERSAMPLE * DIV;
    localparam int BRK_W    = $clog2(BRK_CLKS + 1);

    logic [BRK_W-1:0] r_brk_cnt;
    logic             r_break;

    // A zero word with a bad stop and the line still low is the start of a break.
    assign w_break_frame = w_ferr_now && (r_shift == '0) && !w_rx;
    assign break_det     = r_break;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_brk_cnt <= '0;
            r_break   <= 1'b0;
        end else begin
            r_break <= 1'b0;
            if (w_rx) begin
                r_brk_cnt <= '0;
            end else if (r_brk_cnt != BRK_W'(BRK_CLKS)) begin
                r_brk_cnt <= r_brk_cnt + 1'b1;
                if (r_brk_cnt == BRK_W'(BRK_CLKS - 1)) begin
                    r_break <= 1'b1;
                end
            end
        end
    end
`else
    assign w_break_frame = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_seen_high <= 1'b0;
            r_div_cnt   <= '0;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_samp0     <= 1'b1;
            r_samp1     <= 1'b1;
            r_shift     <= '0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_perr_o    <= 1'b0;
            r_ferr_o    <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_overrun <= 1'b0;
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;

            if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end

            if (r_state == ST_IDLE) begin
                // A falling edge only counts once the line has been seen high.
                if (w_rx) begin
                    r_seen_high <= 1'b1;
                end else if (r_seen_high) begin
                    r_state     <= ST_START;
                    r_seen_high <= 1'b0;
                    r_div_cnt   <= '0;
                    r_tick_cnt  <= '0;
                    r_bit_cnt   <= '0;
                    r_perr      <= 1'b0;
                    r_ferr      <= 1'b0;
                end
            end else if (w_tick) begin
                r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
                if (r_tick_cnt == S0) r_samp0 <= w_rx;
                if (r_tick_cnt == S1) r_samp1 <= w_rx;

                case (r_state)
                    ST_START: begin
                        if (w_mid && w_vote) begin
                            r_state <= ST_IDLE;
                        end else if (w_end) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (w_mid) begin
                            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        end
                        if (w_end) begin
                            if (r_bit_cnt == DATA_LAST) begin
                                r_state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_mid) begin
                            r_perr <= w_par_bad;
                        end
                        if (w_end) begin
                            r_state   <= ST_STOP;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_STOP: begin
                        if (w_mid) begin
                            r_ferr <= w_ferr_now;
                            // Leave at the last stop's vote so an early next start is caught.
                            if (r_bit_cnt == STOP_LAST) begin
                                r_state <= ST_IDLE;
                                if (!w_break_frame) begin
                                    if (w_can_load) begin
                                        r_data   <= r_shift;
                                        r_perr_o <= r_perr;
                                        r_ferr_o <= w_ferr_now;
                                        r_valid  <= 1'b1;
                                    end else begin
                                        r_overrun <= 1'b1;
                                    end
                                end
                            end
                        end else if (w_end) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_perr_o;
    assign frame_err  = r_ferr_o;
    assign overrun    = r_overrun;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: a default 8N1 instance (A) and a fast 7E2, 8x-oversampled instance (B).
module tb_uart_rx_cfg;

    localparam int A_DIV = 27;
    localparam int A_BIT = A_DIV * 16;
    localparam int B_BIT = 8 * 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       rx_a, ready_a, valid_a, perr_a, ferr_a, overrun_a;
    logic [7:0] data_a;
    logic [2:0] dbg_a;
    logic       rx_b, ready_b, valid_b, perr_b, ferr_b, overrun_b;
    logic [6:0] data_b;
    logic [2:0] dbg_b;
`ifdef UART_RX_BREAK_DET_EN
    logic       brk_a, brk_b;
`endif

    uart_rx_cfg u_dut_a (
        .clk(clk), .rst(rst), .rx(rx_a),
        .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
        .parity_err(perr_a), .frame_err(ferr_a), .overrun(overrun_a),
`ifdef UART_RX_BREAK_DET_EN
        .break_det(brk_a),
`endif
        .dbg_state(dbg_a)
    );

    uart_rx_cfg #(
        .CLK_FREQ(1_000_000), .BAUD(15_625), .OVERSAMPLE(8),
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .rx(rx_b),
        .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
        .parity_err(perr_b), .frame_err(ferr_b), .overrun(overrun_b),
`ifdef UART_RX_BREAK_DET_EN
        .break_det(brk_b),
`endif
        .dbg_state(dbg_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_a    = 0;
    int ovr_b    = 0;
    bit rand_ready_b = 1'b0;

    // Scoreboard entries: {parity_err, frame_err, data[8:0]}
    logic [10:0] exp_q_a[$];
    logic [10:0] exp_q_b[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic hold_line(input int inst, input logic val, input int clocks);
        if (inst == 0) rx_a = val;
        else rx_b = val;
        repeat (clocks) @(posedge clk);
        #1;
    endtask

    // Builds the line waveform from the frame rules; stop_low marks stop bits driven 0.
    task automatic send_frame(input int inst, input logic [8:0] data, input logic par_flip,
                              input logic [1:0] stop_low, input int gap);
        int   nb;
        int   bp;
        int   ns;
        logic p;
        nb = (inst == 0) ? 8 : 7;
        bp = (inst == 0) ? A_BIT : B_BIT;
        ns = (inst == 0) ? 1 : 2;
        hold_line(inst, 1'b0, bp);
        p = 1'b0;
        for (int i = 0; i < nb; i++) begin
            hold_line(inst, data[i], bp);
            p = p ^ data[i];
        end
        if (inst == 1) hold_line(inst, p ^ par_flip, bp);
        for (int s = 0; s < ns; s++) hold_line(inst, ~stop_low[s], bp);
        hold_line(inst, 1'b1, gap);
    endtask

    task automatic push_exp(input int inst, input logic [8:0] data, input logic pe, input logic fe);
        if (inst == 0) exp_q_a.push_back({pe, fe, data});
        else exp_q_b.push_back({pe, fe, data});
    endtask

    task automatic wait_valid(input int inst, input int max_cycles, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < max_cycles) begin
            @(negedge clk);
            n++;
            if ((inst == 0 && valid_a) || (inst == 1 && valid_b)) ok = 1'b1;
        end
    endtask

    logic [10:0] held_a;
    logic        hold_a = 1'b0;
    always @(negedge clk) begin
        logic [10:0] e;
        if (rst) begin
            hold_a = 1'b0;
        end else begin
            if (overrun_a) ovr_a++;
            if (hold_a) check("hold_a", 32'({valid_a, perr_a, ferr_a, data_a}), 32'(held_a));
            if (valid_a && ready_a) begin
                if (exp_q_a.size() == 0) begin
                    check("spurious_a", 32'(valid_a), 32'(0));
                end else begin
                    e = exp_q_a.pop_front();
                    check("data_a", 32'(data_a), 32'(e[7:0]));
                    check("perr_a", 32'(perr_a), 32'(e[10]));
                    check("ferr_a", 32'(ferr_a), 32'(e[9]));
                end
            end
            hold_a = valid_a && !ready_a;
            held_a = {valid_a, perr_a, ferr_a, data_a};
        end
    end

    logic [10:0] held_b;
    logic        hold_b = 1'b0;
    always @(negedge clk) begin
        logic [10:0] e;
        if (rst) begin
            hold_b = 1'b0;
        end else begin
            if (overrun_b) ovr_b++;
            if (hold_b) check("hold_b", 32'({valid_b, perr_b, ferr_b, data_b}), 32'(held_b));
            if (valid_b && ready_b) begin
                if (exp_q_b.size() == 0) begin
                    check("spurious_b", 32'(valid_b), 32'(0));
                end else begin
                    e = exp_q_b.pop_front();
                    check("data_b", 32'(data_b), 32'(e[6:0]));
                    check("perr_b", 32'(perr_b), 32'(e[10]));
                    check("ferr_b", 32'(ferr_b), 32'(e[9]));
                end
            end
            hold_b = valid_b && !ready_b;
            held_b = {1'b0, valid_b, perr_b, ferr_b, data_b};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready_b) ready_b = 1'($urandom_range(0, 1));
        end
    end

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_data_a"}, 32'(data_a), 32'(0));
        check({tag, "_valid_a"}, 32'(valid_a), 32'(0));
        check({tag, "_perr_a"}, 32'(perr_a), 32'(0));
        check({tag, "_ferr_a"}, 32'(ferr_a), 32'(0));
        check({tag, "_ovr_a"}, 32'(overrun_a), 32'(0));
        check({tag, "_state_a"}, 32'(dbg_a), 32'(0));
        check({tag, "_data_b"}, 32'(data_b), 32'(0));
        check({tag, "_valid_b"}, 32'(valid_b), 32'(0));
        check({tag, "_state_b"}, 32'(dbg_b), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          ok;
        int          lat;
        int          lo;
        int          hi;
        int          ovr_base;
        logic [8:0]  d;
        logic        fl;
        logic [1:0]  sm;

        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // 1: 0xA5 on 8N1, latency to rx_valid and one-cycle valid with ready high
        push_exp(0, 9'h0A5, 1'b0, 1'b0);
        lo = (19 * A_BIT) / 2 + 3 - 3 * A_DIV;
        hi = (19 * A_BIT) / 2 + 3 + 3 * A_DIV;
        fork
            send_frame(0, 9'h0A5, 1'b0, 2'b00, 20);
            begin
                wait_valid(0, 12 * A_BIT, ok, lat);
                check("a5_valid_seen", 32'(ok), 32'(1));
                check("a5_latency_window", 32'(ok && lat >= lo && lat <= hi), 32'(1));
                @(negedge clk);
                check("a5_valid_one_cycle", 32'(valid_a), 32'(0));
            end
        join

        // 2: short low glitch is a false start
        hold_line(0, 1'b0, 100);
        hold_line(0, 1'b1, 400);
        @(negedge clk);
        check("glitch_idle", 32'(dbg_a), 32'(0));
        check("glitch_no_valid", 32'(valid_a), 32'(0));
        @(posedge clk);
        #1;
        push_exp(0, 9'h03C, 1'b0, 1'b0);
        send_frame(0, 9'h03C, 1'b0, 2'b00, 20);

        // 4: stop bit low gives frame_err, next frame clean
        push_exp(0, 9'h055, 1'b0, 1'b1);
        send_frame(0, 9'h055, 1'b0, 2'b01, 50);
        push_exp(0, 9'h012, 1'b0, 1'b0);
        send_frame(0, 9'h012, 1'b0, 2'b00, 20);
        check("drain_a1", 32'(exp_q_a.size()), 32'(0));

        // 5: consumer stalled, second frame dropped with one overrun pulse
        ready_a  = 1'b0;
        ovr_base = ovr_a;
        push_exp(0, 9'h011, 1'b0, 1'b0);
        send_frame(0, 9'h011, 1'b0, 2'b00, 0);
        send_frame(0, 9'h022, 1'b0, 2'b00, 100);
        @(negedge clk);
        check("ovr_count", 32'(ovr_a - ovr_base), 32'(1));
        check("ovr_held_valid", 32'(valid_a), 32'(1));
        check("ovr_held_data", 32'(data_a), 32'(8'h11));
        @(posedge clk);
        #1;
        ready_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_valid_drop", 32'(valid_a), 32'(0));
        repeat (500) @(posedge clk);
        #1;
        check("drain_a2", 32'(exp_q_a.size()), 32'(0));

        // Random frames on A with ready held high
        ovr_base = ovr_a;
        for (int k = 0; k < 4; k++) begin
            d  = 9'($urandom_range(1, 255));
            sm = 2'($urandom_range(0, 3) == 0);
            push_exp(0, d, 1'b0, sm[0]);
            send_frame(0, d, 1'b0, sm, $urandom_range(10, 200));
        end
        repeat (50) @(posedge clk);
        #1;
        check("drain_a3", 32'(exp_q_a.size()), 32'(0));
        check("no_ovr_a_rand", 32'(ovr_a - ovr_base), 32'(0));

        // 3: even parity on 7E2, wrong then correct parity bit
        push_exp(1, 9'h03C, 1'b1, 1'b0);
        send_frame(1, 9'h03C, 1'b1, 2'b00, 20);
        push_exp(1, 9'h03C, 1'b0, 1'b0);
        send_frame(1, 9'h03C, 1'b0, 2'b00, 20);

        // 6: 0x7F on 7E2, then reset mid-frame and a clean 0x01
        push_exp(1, 9'h07F, 1'b0, 1'b0);
        send_frame(1, 9'h07F, 1'b0, 2'b00, 20);
        check("drain_b1", 32'(exp_q_b.size()), 32'(0));
        hold_line(1, 1'b0, B_BIT);
        hold_line(1, 1'b1, 2 * B_BIT);
        hold_line(1, 1'b0, B_BIT / 2);
        rst  = 1'b1;
        rx_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midreset");
        push_exp(1, 9'h001, 1'b0, 1'b0);
        send_frame(1, 9'h001, 1'b0, 2'b00, 20);

        // Random frames on B with a randomly stalling consumer
        ovr_base     = ovr_b;
        rand_ready_b = 1'b1;
        for (int k = 0; k < 16; k++) begin
            d  = 9'($urandom_range(0, 127));
            fl = 1'($urandom_range(0, 1));
            sm = 2'($urandom_range(0, 3));
            if (sm != 2'b00) d[0] = 1'b1;
            push_exp(1, d, fl, |sm);
            send_frame(1, d, fl, sm, $urandom_range(10, 60));
        end
        rand_ready_b = 1'b0;
        #2;
        ready_b = 1'b1;
        wait_valid(1, 20, ok, lat);
        repeat (20) @(posedge clk);
        #1;
        check("drain_b2", 32'(exp_q_b.size()), 32'(0));
        check("no_ovr_b_rand", 32'(ovr_b - ovr_base), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
